// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control and its ALU control decoder.
package multicycle_main_control_pkg;

    typedef enum logic [3:0] {
        SReset   = 4'd0,
        SFetch   = 4'd1,
        SDecode  = 4'd2,
        SExecR   = 4'd3,
        SWbR     = 4'd4,
        SExecI   = 4'd5,
        SWbI     = 4'd6,
        SMemAddr = 4'd7,
        SMemRd   = 4'd8,
        SMemWb   = 4'd9,
        SMemWr   = 4'd10,
        SBranch  = 4'd11,
        SJump    = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [2:0] AluNone  = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluLw    = 3'b010;
    localparam logic [2:0] AluSw    = 3'b011;
    localparam logic [2:0] AluAdd   = 3'b100;
    localparam logic [2:0] AluOr    = 3'b101;
    localparam logic [2:0] AluAnd   = 3'b110;
    localparam logic [2:0] AluRtype = 3'b111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcReg    = 2'b11;

    localparam logic [1:0] RegDstRt = 2'b00;
    localparam logic [1:0] RegDstRd = 2'b01;
    localparam logic [1:0] RegDstRa = 2'b10;

    localparam logic [1:0] MemToRegAlu = 2'b00;
    localparam logic [1:0] MemToRegMdr = 2'b01;
    localparam logic [1:0] MemToRegPc  = 2'b10;

    typedef struct packed {
        logic r;
        logic arith_i;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic illegal;
    } op_class_t;

    // {ExtOp, ALUOp} for the immediate arithmetic group.
    function automatic logic [3:0] imm_alu_ctl(input logic [5:0] op);
        unique case (op)
            OpOri:   imm_alu_ctl = {1'b1, AluOr};
            OpAndi:  imm_alu_ctl = {1'b1, AluAnd};
            default: imm_alu_ctl = {1'b0, AluAdd};
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_control_opcode_class_decoder.sv
// Combinational opcode classifier: one-hot instruction class plus BNE/JAL variants.
module opcode_class_decoder
    import multicycle_main_control_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic       is_bne,
    output logic       is_jal
);

    always_comb begin
        op_class = '0;
        is_bne   = 1'b0;
        is_jal   = 1'b0;
        unique case (opcode)
            OpRtype:              op_class.r       = 1'b1;
            OpAddi, OpOri, OpAndi: op_class.arith_i = 1'b1;
            OpLw:                 op_class.load    = 1'b1;
            OpSw:                 op_class.store   = 1'b1;
            OpBeq:                op_class.branch  = 1'b1;
            OpBne: begin
                op_class.branch = 1'b1;
                is_bne          = 1'b1;
            end
            OpJ:                  op_class.jump    = 1'b1;
            OpJal: begin
                op_class.jump = 1'b1;
                is_jal        = 1'b1;
            end
            default:              op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences each instruction and drives all datapath controls.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Opcode,
    input  logic                   Zero,
    input  logic                   JR,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic                   ExtOp,
    output logic [1:0]             PCSource,
    output logic [2:0]             ALUOp,
    output logic                   IllegalOp,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   retire;
    op_class_t              op_class;
    logic                   is_bne, is_jal;
    logic [3:0]             imm_ctl;

    opcode_class_decoder u_opcode_class_decoder (
        .opcode   (Opcode),
        .op_class (op_class),
        .is_bne   (is_bne),
        .is_jal   (is_jal)
    );

    assign imm_ctl    = imm_alu_ctl(Opcode);
    assign InstrCount = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SReset;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = RegDstRt;
        MemtoReg  = MemToRegAlu;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SrcBReg;
        ExtOp     = 1'b0;
        PCSource  = PcSrcAlu;
        ALUOp     = AluNone;
        IllegalOp = 1'b0;

        unique case (state_q)
            SReset: state_d = SFetch;
            SFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                ALUOp   = AluAdd;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = SDecode;
                end
            end
            SDecode: begin
                // Branch target is computed speculatively into ALUOut.
                ALUSrcB = SrcBImmSh;
                ALUOp   = AluAdd;
                if (op_class.r)                          state_d = SExecR;
                else if (op_class.arith_i)               state_d = SExecI;
                else if (op_class.load || op_class.store) state_d = SMemAddr;
                else if (op_class.branch)                state_d = SBranch;
                else if (op_class.jump)                  state_d = SJump;
                else begin
                    IllegalOp = 1'b1;
                    state_d   = SFetch;
                end
            end
            SExecR: begin
                ALUSrcA = 1'b1;
                ALUOp   = AluRtype;
                if (JR) begin
                    PCSource = PcSrcReg;
                    PCWrite  = 1'b1;
                    retire   = 1'b1;
                    state_d  = SFetch;
                end else begin
                    state_d = SWbR;
                end
            end
            SWbR: begin
                RegDst   = RegDstRd;
                RegWrite = 1'b1;
                ALUOp    = AluRtype;
                retire   = 1'b1;
                state_d  = SFetch;
            end
            SExecI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                {ExtOp, ALUOp} = imm_ctl;
                state_d = SWbI;
            end
            SWbI: begin
                RegWrite = 1'b1;
                {ExtOp, ALUOp} = imm_ctl;
                retire   = 1'b1;
                state_d  = SFetch;
            end
            SMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                ALUOp   = op_class.store ? AluSw : AluLw;
                state_d = op_class.store ? SMemWr : SMemRd;
            end
            SMemRd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) state_d = SMemWb;
            end
            SMemWb: begin
                MemtoReg = MemToRegMdr;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = SFetch;
            end
            SMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    retire  = 1'b1;
                    state_d = SFetch;
                end
            end
            SBranch: begin
                ALUSrcA  = 1'b1;
                ALUOp    = AluSub;
                PCSource = PcSrcAluOut;
                PCWrite  = is_bne ? ~Zero : Zero;
                retire   = 1'b1;
                state_d  = SFetch;
            end
            SJump: begin
                PCSource = PcSrcJump;
                PCWrite  = 1'b1;
                if (is_jal) begin
                    RegDst   = RegDstRa;
                    MemtoReg = MemToRegPc;
                    RegWrite = 1'b1;
                end
                retire  = 1'b1;
                state_d = SFetch;
            end
            default: state_d = SReset;
        endcase
    end

endmodule
